// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - seven-segment scan monitor: settles each digit slot and decodes it back to BCD
// Optional SEG_ACTIVE_LOW_EN: inverts seg_select at the input stage for common-anode boards.
module seg_scan_capture #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig_select,
  input  logic [7:0] seg_select,
  output logic [3:0] time_shi,
  output logic [3:0] time_ge,
  output logic [3:0] score_shi,
  output logic [3:0] score_ge,
  output logic       frame_valid,
  output logic       update,
  output logic       seg_err
);

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  // Returns {legal, bcd}; dp bit is not part of the digit.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h3F:   seg_decode = {1'b1, 4'd0};
      7'h06:   seg_decode = {1'b1, 4'd1};
      7'h5B:   seg_decode = {1'b1, 4'd2};
      7'h4F:   seg_decode = {1'b1, 4'd3};
      7'h66:   seg_decode = {1'b1, 4'd4};
      7'h6D:   seg_decode = {1'b1, 4'd5};
      7'h7D:   seg_decode = {1'b1, 4'd6};
      7'h07:   seg_decode = {1'b1, 4'd7};
      7'h7F:   seg_decode = {1'b1, 4'd8};
      7'h6F:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  logic [7:0] seg_in;
`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~seg_select;
`else
  assign seg_in = seg_select;
`endif

  logic [3:0]       r_dig_q, r_dig_d;
  logic [7:0]       r_seg_q, r_seg_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic             frame_valid_q, frame_valid_d;
  logic             update_q, update_d;
  logic             seg_err_q, seg_err_d;

  logic       slot_legal;
  logic [1:0] slot;
  logic       same;
  logic       capture;
  logic [4:0] dec;

  always_comb begin
    slot_legal = 1'b1;
    slot       = 2'd0;
    case (r_dig_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot_legal = 1'b0;
    endcase
  end

  always_comb begin
    same          = ({dig_select, seg_in} == {r_dig_q, r_seg_q});
    dec           = seg_decode(r_seg_q[6:0]);
    r_dig_d       = dig_select;
    r_seg_d       = seg_in;
    cnt_d         = cnt_q;
    seen_d        = seen_q;
    digit_d       = digit_q;
    update_d      = 1'b0;
    seg_err_d     = 1'b0;
    capture       = 1'b0;
    frame_valid_d = frame_valid_q | (seen_q == 4'b1111);

    // Change/idle check wins over saturation; saturating at SETTLE keeps capture to once per dwell.
    if (!same || !slot_legal) begin
      cnt_d = 8'd0;
    end else if (cnt_q < SETTLE_C) begin
      cnt_d   = cnt_q + 8'd1;
      capture = (cnt_q == SETTLE_C - 8'd1);
    end

    if (capture) begin
      if (dec[4]) begin
        digit_d[slot] = dec[3:0];
        seen_d[slot]  = 1'b1;
        update_d      = (digit_q[slot] != dec[3:0]);
      end else begin
        seg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig_q       <= 4'b1111;
      r_seg_q       <= 8'h00;
      cnt_q         <= 8'd0;
      seen_q        <= 4'b0000;
      digit_q       <= '0;
      frame_valid_q <= 1'b0;
      update_q      <= 1'b0;
      seg_err_q     <= 1'b0;
    end else begin
      r_dig_q       <= r_dig_d;
      r_seg_q       <= r_seg_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      digit_q       <= digit_d;
      frame_valid_q <= frame_valid_d;
      update_q      <= update_d;
      seg_err_q     <= seg_err_d;
    end
  end

  assign time_ge     = digit_q[0];
  assign time_shi    = digit_q[1];
  assign score_ge    = digit_q[2];
  assign score_shi   = digit_q[3];
  assign frame_valid = frame_valid_q;
  assign update      = update_q;
  assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - directed self-checking bench for seg_scan_capture (SETTLE=4)
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dig;
  logic [7:0] seg;
  logic [3:0] time_shi, time_ge, score_shi, score_ge;
  logic       frame_valid, update, seg_err;

  int tests = 0;
  int failed = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  seg_scan_capture #(.SETTLE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .dig_select (dig),
    .seg_select (seg),
    .time_shi   (time_shi),
    .time_ge    (time_ge),
    .score_shi  (score_shi),
    .score_ge   (score_ge),
    .frame_valid(frame_valid),
    .update     (update),
    .seg_err    (seg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef SEG_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_raw(input logic [3:0] d, input logic [7:0] s, input int n);
    dig = d;
    seg = s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      upd_cnt += int'(update);
      err_cnt += int'(seg_err);
    end
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    hold_raw(d, enc(s), n);
  endtask

  task automatic clr();
    upd_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    dig = 4'b1111;
    seg = enc(8'h00);
    hold(4'b1111, 8'h00, 2);
    check("reset_digits", {time_shi, time_ge, score_shi, score_ge}, 16'h0000);
    check("reset_flags", {13'd0, frame_valid, update, seg_err}, 16'h0000);
    rst = 1'b0;
    hold(4'b1111, 8'h00, 2);
    check("idle_digits", {time_shi, time_ge, score_shi, score_ge}, 16'h0000);

    // First capture: visible after E0+SETTLE
    clr();
    hold(4'b1110, 8'h06, 4);
    check("first_before_settle", 16'(time_ge), 16'd0);
    hold(4'b1110, 8'h06, 1);
    check("first_capture", 16'(time_ge), 16'd1);
    check("first_update_pulse", 16'(update), 16'd1);
    hold(4'b1110, 8'h06, 5);
    check("first_update_count", 16'(upd_cnt), 16'd1);
    check("first_frame_valid", 16'(frame_valid), 16'd0);

    // Dwell too short
    clr();
    hold(4'b1101, 8'h4F, 4);
    hold(4'b1111, 8'h00, 3);
    check("short_time_shi", 16'(time_shi), 16'd0);
    check("short_pulses", 16'(upd_cnt + err_cnt), 16'd0);

    // Illegal code, then seen[2] must still be clear
    clr();
    hold(4'b1011, 8'h49, 8);
    check("illegal_err_count", 16'(err_cnt), 16'd1);
    check("illegal_score_ge", 16'(score_ge), 16'd0);
    clr();
    hold(4'b1101, 8'h4F, 8);
    hold(4'b0111, 8'h06, 8);
    check("partial_digits", {time_shi, time_ge, score_shi, score_ge}, 16'h3110);
    check("partial_updates", 16'(upd_cnt), 16'd2);
    check("partial_no_frame", 16'(frame_valid), 16'd0);

    // Code change without digit change restarts the dwell
    clr();
    hold(4'b1011, 8'h49, 8);
    check("illegal2_err_count", 16'(err_cnt), 16'd1);
    hold(4'b1011, 8'h7F, 4);
    check("recode_before", 16'(score_ge), 16'd0);
    hold(4'b1011, 8'h7F, 1);
    check("recode_capture", 16'(score_ge), 16'd8);
    check("recode_update", 16'(update), 16'd1);
    check("frame_not_yet", 16'(frame_valid), 16'd0);
    hold(4'b1011, 8'h7F, 1);
    check("frame_rises", 16'(frame_valid), 16'd1);
    hold(4'b1011, 8'h7F, 2);

    // Full scan then a repeat with identical codes
    clr();
    hold(4'b1110, 8'h6D, 8);
    hold(4'b1101, 8'h4F, 8);
    hold(4'b1011, 8'h3F, 8);
    hold(4'b0111, 8'h06, 8);
    check("scan_digits", {time_shi, time_ge, score_shi, score_ge}, 16'h3510);
    check("scan_updates", 16'(upd_cnt), 16'd2);
    check("scan_errs", 16'(err_cnt), 16'd0);
    clr();
    hold(4'b1110, 8'h6D, 8);
    hold(4'b1101, 8'h4F, 8);
    hold(4'b1011, 8'h3F, 8);
    hold(4'b0111, 8'h06, 8);
    check("repeat_updates", 16'(upd_cnt), 16'd0);
    check("repeat_digits", {time_shi, time_ge, score_shi, score_ge}, 16'h3510);
    check("repeat_frame", 16'(frame_valid), 16'd1);

    // Reset mid-dwell (cnt=2)
    hold(4'b1110, 8'h7D, 3);
    rst = 1'b1;
    hold(4'b1110, 8'h7D, 1);
    check("midrst_digits", {time_shi, time_ge, score_shi, score_ge}, 16'h0000);
    check("midrst_flags", {13'd0, frame_valid, update, seg_err}, 16'h0000);
    rst = 1'b0;
    clr();
    hold(4'b1110, 8'h7D, 4);
    check("postrst_before", 16'(time_ge), 16'd0);
    hold(4'b1110, 8'h7D, 1);
    check("postrst_capture", 16'(time_ge), 16'd6);
    check("postrst_update", 16'(upd_cnt), 16'd1);

`ifdef SEG_ACTIVE_LOW_EN
    clr();
    hold_raw(4'b1110, 8'h06, 8);
    check("al_raw06_err", 16'(err_cnt), 16'd1);
    check("al_raw06_keep", 16'(time_ge), 16'd6);
    hold_raw(4'b1110, 8'hF9, 8);
    check("al_F9_one", 16'(time_ge), 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the 4-digit multiplexed seven-segment driver in the whack-a-mole top level. The block watches the time-multiplexed digit select and segment buses, waits for each digit slot to settle, and decodes the segment pattern back to a BCD digit. It reconstructs time tens/ones and score tens/ones as registers. It is used as a self-check monitor in simulation and as an on-board loopback checker feeding debug LEDs.

## Interface
- SETTLE, 4: consecutive cycles a slot's digit select and segment code must be unchanged before capture; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- dig_select  input  4  active-low one-hot digit select: 1110 time ones, 1101 time tens, 1011 score ones, 0111 score tens; any other value is idle.
- seg_select  input  8  segment code, bit order {dp,g,f,e,d,c,b,a}; active-high unless configured otherwise.
- time_shi, time_ge, score_shi, score_ge  output  4 each  captured BCD digits.
- frame_valid  output  1  high once all four slots have been captured with legal codes since reset.
- update  output  1  one-cycle pulse when a capture changes a stored digit.
- seg_err  output  1  one-cycle pulse when a settled code is not a legal digit.

## Operation
- Input stage: r_dig <= dig_select and r_seg <= seg_select on every edge.
- Stability counter cnt, 8 bits, saturating at SETTLE.
  - Reset cnt to 0 when {dig_select, seg_select} != {r_dig, r_seg}, or when r_dig is not one of the four legal patterns.
  - Otherwise cnt increments, saturating at SETTLE.
- Capture occurs on the edge where cnt goes from SETTLE-1 to SETTLE, using r_dig and r_seg.
  - A capture happens only once per dwell. Further captures require cnt to return to 0 first.
- Decode uses seg[6:0]; dp is ignored. Legal codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Legal code at capture:
  - Write the slot's digit register.
  - Set the slot's bit in a 4-bit seen mask.
  - Pulse update if the new value differs from the old value.
- Illegal code at capture, including blank 00:
  - Pulse seg_err.
  - Leave the digit register and seen mask unchanged.
- frame_valid = (seen == 4'b1111), registered. It is sticky until rst.
- States, implicit in cnt: WAIT (cnt=0), SETTLING (0<cnt<SETTLE), HELD (cnt=SETTLE). Any change or idle pattern returns to WAIT.
- Simultaneous events: the input-change test takes priority over saturation. update and seg_err are mutually exclusive.

## Timing
- Reset values:
  - All digit outputs 0; frame_valid, update and seg_err 0.
  - seen 0, cnt 0, r_dig 4'b1111, r_seg 0.
- Latency: inputs change before edge E0 and then stay constant. Capture, including the digit, update and seg_err, is visible after edge E0+SETTLE.
- frame_valid rises on the edge after the fourth distinct slot's capture.
- A dwell shorter than SETTLE+1 cycles produces no capture.
- rst asserted mid-dwell:
  - All state clears on that edge.
  - Capture needs a fresh full dwell counted from the first edge after rst deasserts. The first post-reset edge resets cnt because r_dig is 1111.

## Configuration
- SEG_ACTIVE_LOW_EN defined: seg_select is inverted at the input stage before comparison and decode, for common-anode boards. Legal codes become the bitwise complements of the listed values, e.g. 1 = F9 with dp high.
- SEG_ACTIVE_LOW_EN undefined: active-high decode as listed.
- No other behaviour changes.

## Test plan
- rst, then dig=1110, seg=06 held 10 cycles, SETTLE=4 -> time_ge=1 after the 4th edge, exactly one update pulse, frame_valid 0.
- dig=1101, seg=4F held 4 cycles, then dig=1111 -> no capture, time_shi stays 0, no pulses.
- Full scan, each slot held 8 cycles: 1110/6D, 1101/4F, 1011/3F, 0111/06 -> time=35, score=10, frame_valid rises after the last capture. A repeat scan with the same codes gives zero update pulses.
- dig=1011, seg=49 held 8 cycles -> one seg_err pulse, score_ge unchanged, seen[2] stays 0. Then seg=7F without a dig change -> cnt restarts, score_ge=8 after 4 edges.
- Mid-dwell (cnt=2) assert rst 1 cycle -> all outputs 0. Continued stable input captures 4 edges after the first post-reset edge.
- SEG_ACTIVE_LOW_EN build: 1110/F9 -> time_ge=1. 1110/06 -> seg_err.
